fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of write requesters (fixed 4 in this revision).
REQ-002 The block SHALL have parameter DW, default 8, meaning the data width, which matches the 8-bit FIFO din.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum accepted beats per grant (1..15).
REQ-004 Port clk  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst  input  1  the asynchronous active-low reset (asserted at 0).
REQ-006 Port req  input  N_REQ  per-requester write request; bit i is requester i.
REQ-007 Port req_data  input  N_REQ*DW  requester i data occupies bits [i*DW+DW-1 : i*DW].
REQ-008 Port ack  output  N_REQ  one-hot acceptance strobe: beat accepted this cycle.
REQ-009 Port fifo_full  input  1  full flag from the downstream 16-deep FIFO.
REQ-010 Port fifo_wt_en  output  1  write enable to the FIFO.
REQ-011 Port fifo_din  output  DW  write data to the FIFO.
REQ-012 Port gnt_id  output  2  index of the current owner (valid when busy=1).
REQ-013 Port busy  output  1  high while in GRANT.
REQ-014 Port stall  output  1  high when the owner requests but fifo_full blocks the write.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-016 In IDLE with any req bit set, the block SHALL select the first set bit searching upward from rr_ptr with modulo-N_REQ wrap, register it as owner, clear beat_ct, and enter GRANT on the next edge.
REQ-017 In IDLE with req=0, the state SHALL remain IDLE.
REQ-018 In IDLE, ack, fifo_wt_en and stall SHALL be 0.
REQ-019 In GRANT, fifo_wt_en and ack[owner] SHALL equal req[owner] && !fifo_full combinationally; all other ack bits SHALL be 0.
REQ-020 In GRANT, fifo_din SHALL equal req_data slice [owner] combinationally.
REQ-021 fifo_wt_en SHALL never be 1 while fifo_full=1, so no overflow is ever caused.
REQ-022 Each accepted beat SHALL increment the 4-bit beat_ct.
REQ-023 On an accepted beat with beat_ct==MAX_BURST-1, the block SHALL release: go to IDLE and set rr_ptr to owner+1 mod N_REQ.
REQ-024 If req[owner]=0 in GRANT, the block SHALL release with the same rr_ptr update and no transfer.
REQ-025 While fifo_full=1 and req[owner]=1, the block SHALL hold GRANT, keep owner and beat_ct unchanged, and drive stall=1.
REQ-026 A release SHALL always pass through IDLE, giving a 1-cycle bubble; worst-case wait for a requester SHALL be (N_REQ-1)*(MAX_BURST+1) accepted-or-bubble cycles plus FIFO stall cycles.
REQ-027 Requesters SHALL hold req and req_data stable until ack; the block SHALL NOT buffer data (zero added latency: beat reaches FIFO in the ack cycle).
REQ-028 Changes to non-owner req bits during GRANT SHALL have no effect until the next IDLE.

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, owner=0, rr_ptr=0, beat_ct=0.
REQ-030 During and immediately after reset, outputs SHALL be ack=0, fifo_wt_en=0, fifo_din=0, gnt_id=0, busy=0, stall=0.
REQ-031 Reset asserted mid-burst SHALL abort the burst without completing the current beat; after rst returns to 1, arbitration SHALL restart from requester 0.

Verification
REQ-032 Single requester: req=4'b0010 held, fifo_full=0 -> after 1 IDLE cycle, 4 consecutive ack[1] pulses, 1 bubble, then 4 more.
REQ-033 All requesting: req=4'b1111, fifo_full=0 -> grant order 0,1,2,3,0; each grant 4 beats separated by 1 bubble; fifo_din follows the owner's slice.
REQ-034 Full stall: owner 2 at beat_ct=2, fifo_full=1 for 5 cycles -> stall=1, fifo_wt_en=0, beat_ct stays 2; then 2 more beats and release.
REQ-035 Early drop: owner 3 deasserts req after 1 beat -> release next edge, rr_ptr=0; req=4'b1001 then grants 0.
REQ-036 Reset mid-burst: rst=0 while owner=1 and beat_ct=1 -> outputs 0 immediately; after release with req=4'b0110, requester 1 is granted.
REQ-037 Scoreboard: a sequence of 64 random req/fifo_full patterns -> FIFO receives every acked beat in order, with no write while full and no ack outside GRANT.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: N_REQ requesters share one downstream FIFO write port,
// with bounded bursts, a one-cycle bubble between grants, and stall on fifo_full.
`timescale 1ns/1ps
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    input  logic                fifo_full,
    output logic                fifo_wt_en,
    output logic [DW-1:0]       fifo_din,
    output logic [1:0]          gnt_id,
    output logic                busy,
    output logic                stall
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] rr_ptr;
    logic [3:0] beat_ct;
    logic [1:0] pick;
    logic       owner_req;
    logic       accept;

    // First requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        logic found;
        logic [1:0] idx;
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 2'((32'(rr_ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign owner_req = req[owner];
    assign accept    = (state == GRANT) && owner_req && !fifo_full;

    always_comb begin
        ack        = '0;
        ack[owner] = accept;
        fifo_wt_en = accept;
        stall      = (state == GRANT) && owner_req && fifo_full;
        fifo_din   = (state == GRANT) ? req_data[32'(owner)*DW +: DW] : '0;
    end

    assign gnt_id = owner;
    assign busy   = (state == GRANT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            beat_ct <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner   <= pick;
                        beat_ct <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        state  <= IDLE;
                        rr_ptr <= owner + 2'd1;
                    end else if (!fifo_full) begin
                        beat_ct <= beat_ct + 4'd1;
                        if (beat_ct == 4'(MAX_BURST - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= owner + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed vector table, hand-written corner sequences,
// and a randomized run checked against a cycle-level reference model and data scoreboard.
`timescale 1ns/1ps
module tb_fifo_wr_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wt_en;
    logic [7:0]  fifo_din;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        stall;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] DATA = 32'hD3C2B1A0;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arb #(.N_REQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .fifo_full(fifo_full), .fifo_wt_en(fifo_wt_en), .fifo_din(fifo_din),
        .gnt_id(gnt_id), .busy(busy), .stall(stall)
    );

    typedef struct {
        logic [3:0] r;
        logic       f;
        logic [3:0] a;
        logic       b;
        logic [1:0] g;
        logic       s;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic [3:0] r, logic f, logic [3:0] a, logic b, logic [1:0] g, logic s);
        vec_t v;
        v.r = r; v.f = f; v.a = a; v.b = b; v.g = g; v.s = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then step past the edge.
    task automatic apply(input string tag, input logic [3:0] r, input logic f,
                         input logic [3:0] e_ack, input logic e_busy, input logic [1:0] e_gnt,
                         input logic e_stall);
        logic [7:0] e_din;
        logic [31:0] d;
        d = DATA;
        e_din = e_busy ? d[32'(e_gnt)*8 +: 8] : 8'h00;
        req = r;
        fifo_full = f;
        @(negedge clk);
        chk(tag, {15'd0, ack, fifo_wt_en, fifo_din, gnt_id, busy, stall},
                 {15'd0, e_ack, |e_ack, e_din, e_gnt, e_busy, e_stall});
        chk({tag, " protocol"}, {30'd0, fifo_wt_en && fifo_full, (|ack) && !busy}, 32'd0);
        if (fifo_wt_en) obs_q.push_back(fifo_din);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        fifo_full = 1'b0;
        rst = 1'b0;
        #1;
        chk("reset outputs", {15'd0, ack, fifo_wt_en, fifo_din, gnt_id, busy, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: owner index or -1 when no grant is held.
    int m_own, m_beats, m_next, m_gnt;

    initial begin
        logic [3:0] r_cur;
        logic       f_cur;
        logic [3:0] e_ack;
        logic       acc;

        req_data = DATA;
        req = '0;
        fifo_full = 1'b0;
        rst = 1'b1;
        #2;

        // Single requester, stall, early drop
        tbl[0] = mk(4'b0010, 0, 4'b0000, 0, 2'd0, 0);
        for (int i = 1; i <= 4; i++) tbl[i] = mk(4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        tbl[5] = mk(4'b0010, 0, 4'b0000, 0, 2'd1, 0);
        for (int i = 6; i <= 9; i++) tbl[i] = mk(4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        tbl[10] = mk(4'b0100, 0, 4'b0000, 0, 2'd1, 0);
        tbl[11] = mk(4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        tbl[12] = mk(4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        for (int i = 13; i <= 17; i++) tbl[i] = mk(4'b0100, 1, 4'b0000, 1, 2'd2, 1);
        tbl[18] = mk(4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        tbl[19] = mk(4'b0100, 0, 4'b0100, 1, 2'd2, 0);
        tbl[20] = mk(4'b1000, 0, 4'b0000, 0, 2'd2, 0);
        tbl[21] = mk(4'b1000, 0, 4'b1000, 1, 2'd3, 0);
        tbl[22] = mk(4'b0000, 0, 4'b0000, 1, 2'd3, 0);
        tbl[23] = mk(4'b1001, 0, 4'b0000, 0, 2'd3, 0);
        tbl[24] = mk(4'b1001, 0, 4'b0001, 1, 2'd0, 0);

        do_reset();
        for (int i = 0; i < 25; i++)
            apply($sformatf("vec%0d", i), tbl[i].r, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].s);

        // All requesting: grant order 0,1,2,3,0 with bubbles
        do_reset();
        apply("all idle", 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++)
                apply($sformatf("all g%0d b%0d", g, b), 4'b1111, 0, 4'b0001 << (g % 4), 1, 2'(g % 4), 0);
            if (g < 4) apply($sformatf("all bubble%0d", g), 4'b1111, 0, 4'b0000, 0, 2'(g % 4), 0);
        end

        // Reset mid-burst: owner 1 at beat_ct 1
        do_reset();
        apply("mid idle", 4'b0010, 0, 4'b0000, 0, 2'd0, 0);
        apply("mid beat0", 4'b0010, 0, 4'b0010, 1, 2'd1, 0);
        req = 4'b0010;
        #2;
        chk("mid pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid async reset outputs", {15'd0, ack, fifo_wt_en, fifo_din, gnt_id, busy, stall}, 32'd0);
        req = 4'b0110;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply("mid regrant", 4'b0110, 0, 4'b0010, 1, 2'd1, 0);

        // Randomized run against the reference model
        do_reset();
        obs_q.delete();
        exp_q.delete();
        m_own = -1; m_beats = 0; m_next = 0; m_gnt = 0;
        r_cur = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if ($urandom_range(3) == 0) r_cur = 4'($urandom);
            f_cur = ($urandom_range(4) == 0);
            if (m_own < 0) begin
                apply($sformatf("rand%0d", cyc), r_cur, f_cur, 4'b0000, 0, 2'(m_gnt), 0);
                if (r_cur != 0) begin
                    for (int j = 3; j >= 0; j--)
                        if (r_cur[(m_next + j) % 4]) m_own = (m_next + j) % 4;
                    m_gnt = m_own;
                    m_beats = 0;
                end
            end else begin
                acc = r_cur[m_own] && !f_cur;
                e_ack = acc ? (4'b0001 << m_own) : 4'b0000;
                apply($sformatf("rand%0d", cyc), r_cur, f_cur, e_ack, 1, 2'(m_own),
                      r_cur[m_own] && f_cur);
                if (acc) begin
                    exp_q.push_back(DATA[m_own*8 +: 8]);
                    m_beats++;
                end
                if (!r_cur[m_own] || m_beats == 4) begin
                    m_next = (m_own + 1) % 4;
                    m_own = -1;
                end
            end
        end
        chk("scoreboard count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("scoreboard beat%0d", i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
